// File: rtl/control_unit.sv
// control_unit: single-cycle RV64I decoder and ALU with a sticky EBREAK halt register.
// Optional RV64 word instructions (ADDIW..SRAW) are enabled by defining RV64_WORD_OPS_EN.
module control_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] alu_res,
  output logic            pc_sel,
  output logic            reg_wen,
  output logic [1:0]      reg_w_sel,
  output logic            mem_wen,
  output logic            mem_ren,
  output logic [7:0]      mem_mask,
  output logic            ebreak_flag,
  output logic            illegal,
  output logic            halted
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
`ifdef RV64_WORD_OPS_EN
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_OP_32     = 7'h3B;
`endif
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  alu_op_t     op;
  logic        a_pc, b_rs2, wen_d, mwen_d, mren_d, psel_d, bad, jalr_d, is_mem, word;
  logic [1:0]  wsel_d;
  logic [XLEN-1:0] imm_v;

  always_comb begin
    op = ALU_ADD; a_pc = 1'b0; b_rs2 = 1'b0; wen_d = 1'b0; mwen_d = 1'b0;
    mren_d = 1'b0; psel_d = 1'b0; bad = 1'b0; jalr_d = 1'b0; is_mem = 1'b0;
    word = 1'b0; wsel_d = 2'd0; imm_v = '0;
    case (opcode)
      OPC_LUI:   begin imm_v = imm_u; op = ALU_PASS_B; wen_d = 1'b1; end
      OPC_AUIPC: begin imm_v = imm_u; a_pc = 1'b1; wen_d = 1'b1; end
      OPC_JAL: begin
        imm_v = imm_j; a_pc = 1'b1; psel_d = 1'b1; wen_d = 1'b1; wsel_d = 2'd2;
      end
      OPC_JALR: begin
        imm_v = imm_i; psel_d = 1'b1; wen_d = 1'b1; wsel_d = 2'd2; jalr_d = 1'b1;
        bad = (funct3 != 3'd0);
      end
      OPC_LOAD: begin
        imm_v = imm_i; mren_d = 1'b1; wen_d = 1'b1; wsel_d = 2'd1; is_mem = 1'b1;
        bad = (funct3 == 3'd7);
      end
      OPC_STORE: begin
        imm_v = imm_s; mwen_d = 1'b1; is_mem = 1'b1;
        bad = funct3[2];
      end
      OPC_OP_IMM: begin
        // inst[30] only selects SRAI; for other funct3 it is an immediate bit
        imm_v = imm_i; wen_d = 1'b1;
        op = arith_op(funct3, inst[30] && (funct3 == 3'd5));
        if (funct3 == 3'd1) bad = (inst[31:26] != 6'd0);
        if (funct3 == 3'd5) bad = ({inst[31], inst[29:26]} != 5'd0);
      end
      OPC_OP: begin
        b_rs2 = 1'b1; wen_d = 1'b1;
        op = arith_op(funct3, inst[30]);
        bad = !((funct7 == 7'h00) ||
                ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
`ifdef RV64_WORD_OPS_EN
      OPC_OP_IMM_32: begin
        imm_v = imm_i; wen_d = 1'b1; word = 1'b1;
        op = arith_op(funct3, inst[30] && (funct3 == 3'd5));
        case (funct3)
          3'd0:    bad = 1'b0;
          3'd1:    bad = (funct7 != 7'h00);
          3'd5:    bad = (funct7 != 7'h00) && (funct7 != 7'h20);
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        b_rs2 = 1'b1; wen_d = 1'b1; word = 1'b1;
        op = arith_op(funct3, inst[30]);
        case (funct3)
          3'd0, 3'd5: bad = (funct7 != 7'h00) && (funct7 != 7'h20);
          3'd1:       bad = (funct7 != 7'h00);
          default:    bad = 1'b1;
        endcase
      end
`endif
      OPC_SYSTEM: bad = (inst != INST_EBREAK);
      default:    bad = 1'b1;
    endcase
  end

  logic [XLEN-1:0] a, b, res;
  assign a = a_pc ? pc : rs1_data;
  assign b = b_rs2 ? rs2_data : imm_v;

  always_comb begin
    case (op)
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << b[5:0];
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  res = a ^ b;
      ALU_SRL:  res = a >> b[5:0];
      ALU_SRA:  res = $signed(a) >>> b[5:0];
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_PASS_B: res = b;
      default:  res = a + b;
    endcase
  end

`ifdef RV64_WORD_OPS_EN
  logic [31:0] wres;
  always_comb begin
    case (op)
      ALU_SUB: wres = a[31:0] - b[31:0];
      ALU_SLL: wres = a[31:0] << b[4:0];
      ALU_SRL: wres = a[31:0] >> b[4:0];
      ALU_SRA: wres = $signed(a[31:0]) >>> b[4:0];
      default: wres = a[31:0] + b[31:0];
    endcase
  end
`endif

  always_comb begin
    alu_res = res;
`ifdef RV64_WORD_OPS_EN
    if (word) alu_res = {{(XLEN-32){wres[31]}}, wres};
`endif
    if (jalr_d) alu_res = {res[XLEN-1:1], 1'b0};
    if (bad) alu_res = '0;
  end

  always_comb begin
    case (funct3[1:0])
      2'd0:    mem_mask = 8'h01;
      2'd1:    mem_mask = 8'h03;
      2'd2:    mem_mask = 8'h0F;
      default: mem_mask = 8'hFF;
    endcase
    if (!is_mem || bad) mem_mask = 8'h00;
  end

  assign imm         = imm_v;
  assign ebreak_flag = (inst == INST_EBREAK);
  assign illegal     = bad;
  assign pc_sel      = psel_d & ~bad;
  assign reg_w_sel   = bad ? 2'd0 : wsel_d;
  assign reg_wen     = wen_d & ~bad & ~halted;
  assign mem_wen     = mwen_d & ~bad & ~halted;
  assign mem_ren     = mren_d & ~bad & ~halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted <= 1'b0;
    else if (ebreak_flag) halted <= 1'b1;
  end

  logic unused_word;
  assign unused_word = word;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model checked every cycle,
// plus literal expectations on key instructions and the halt/reset behaviour.
module tb_control_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst;
  logic [63:0] pc, rs1_data, rs2_data, imm, alu_res;
  logic        pc_sel, reg_wen, mem_wen, mem_ren, ebreak_flag, illegal, halted;
  logic [1:0]  reg_w_sel;
  logic [7:0]  mem_mask;

  int checks = 0;
  int errors = 0;
  logic exp_halted = 1'b0;

  control_unit #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .pc(pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .alu_res(alu_res), .pc_sel(pc_sel),
    .reg_wen(reg_wen), .reg_w_sel(reg_w_sel), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_mask(mem_mask), .ebreak_flag(ebreak_flag), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] alu;
    logic        pc_sel, reg_wen;
    logic [1:0]  wsel;
    logic        mwen, mren;
    logic [7:0]  mask;
    logic        ebreak, illegal, chk_imm, chk_alu;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h inst=%h", name, act, exp, inst);
    end
  endtask

  function automatic logic [63:0] arith(input logic [2:0] f3, input logic alt,
                                        input logic [63:0] x, input logic [63:0] y);
    case (f3)
      3'd0:    return alt ? x - y : x + y;
      3'd1:    return x << y[5:0];
      3'd2:    return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      3'd3:    return (x < y) ? 64'd1 : 64'd0;
      3'd4:    return x ^ y;
      3'd5:    return alt ? 64'($signed(x) >>> y[5:0]) : x >> y[5:0];
      3'd6:    return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [63:0] word_arith(input logic [2:0] f3, input logic alt,
                                             input logic [63:0] x, input logic [63:0] y);
    logic [31:0] lo;
    case (f3)
      3'd0:    lo = alt ? x[31:0] - y[31:0] : x[31:0] + y[31:0];
      3'd1:    lo = x[31:0] << y[4:0];
      default: lo = alt ? 32'($signed(x[31:0]) >>> y[4:0]) : x[31:0] >> y[4:0];
    endcase
    return {{32{lo[31]}}, lo};
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [63:0] p,
                                 input logic [63:0] x, input logic [63:0] y, input logic h);
    exp_t e;
    logic ok;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [63:0] ii, si, ui, ji;
    int nb;
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ii = {{52{i[31]}}, i[31:20]};
    si = {{52{i[31]}}, i[31:25], i[11:7]};
    ui = {{32{i[31]}}, i[31:12], 12'h000};
    ji = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    nb = 1 << f3[1:0];
    e = '0; e.chk_imm = 1'b1; e.chk_alu = 1'b1; ok = 1'b1;
    case (opc)
      7'h37: begin e.imm = ui; e.alu = ui; e.reg_wen = 1'b1; end
      7'h17: begin e.imm = ui; e.alu = p + ui; e.reg_wen = 1'b1; end
      7'h6F: begin e.imm = ji; e.alu = p + ji; e.pc_sel = 1'b1; e.reg_wen = 1'b1; e.wsel = 2'd2; end
      7'h67: begin
        e.imm = ii; e.alu = (x + ii) & ~64'd1; e.pc_sel = 1'b1; e.reg_wen = 1'b1; e.wsel = 2'd2;
        ok = (f3 == 3'd0);
      end
      7'h03: begin
        e.imm = ii; e.alu = x + ii; e.mren = 1'b1; e.reg_wen = 1'b1; e.wsel = 2'd1;
        e.mask = 8'((1 << nb) - 1); ok = (f3 != 3'd7);
      end
      7'h23: begin
        e.imm = si; e.alu = x + si; e.mwen = 1'b1; e.mask = 8'((1 << nb) - 1); ok = (f3 < 3'd4);
      end
      7'h13: begin
        e.imm = ii; e.reg_wen = 1'b1; e.alu = arith(f3, (f3 == 3'd5) && i[30], x, ii);
        if (f3 == 3'd1) ok = (i[31:26] == 6'h00);
        if (f3 == 3'd5) ok = (i[31:26] == 6'h00) || (i[31:26] == 6'h10);
      end
      7'h33: begin
        e.reg_wen = 1'b1; e.alu = arith(f3, i[30], x, y);
        ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
`ifdef RV64_WORD_OPS_EN
      7'h1B: begin
        e.imm = ii; e.reg_wen = 1'b1; e.alu = word_arith(f3, (f3 == 3'd5) && i[30], x, ii);
        ok = (f3 == 3'd0) || ((f3 == 3'd1) && (f7 == 7'h00)) ||
             ((f3 == 3'd5) && ((f7 == 7'h00) || (f7 == 7'h20)));
      end
      7'h3B: begin
        e.reg_wen = 1'b1; e.alu = word_arith(f3, i[30], x, y);
        ok = ((f3 == 3'd1) && (f7 == 7'h00)) ||
             (((f3 == 3'd0) || (f3 == 3'd5)) && ((f7 == 7'h00) || (f7 == 7'h20)));
      end
`endif
      7'h73: begin e.ebreak = (i == 32'h0010_0073); ok = e.ebreak; e.chk_alu = 1'b0; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.illegal = 1'b1; e.pc_sel = 1'b0; e.reg_wen = 1'b0; e.mwen = 1'b0; e.mren = 1'b0;
      e.mask = 8'h00; e.wsel = 2'd0; e.alu = '0; e.chk_imm = 1'b0; e.chk_alu = 1'b1;
    end
    if (h) begin e.reg_wen = 1'b0; e.mwen = 1'b0; e.mren = 1'b0; end
    return e;
  endfunction

  // Halt rule: EBREAK seen at a rising edge halts; reset clears at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_halted <= 1'b0;
    else if (inst == 32'h0010_0073) exp_halted <= 1'b1;
  end

  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      e = model(inst, pc, rs1_data, rs2_data, exp_halted);
      chk("halted", 64'(halted), 64'(exp_halted));
      chk("illegal", 64'(illegal), 64'(e.illegal));
      chk("ebreak_flag", 64'(ebreak_flag), 64'(e.ebreak));
      chk("pc_sel", 64'(pc_sel), 64'(e.pc_sel));
      chk("reg_wen", 64'(reg_wen), 64'(e.reg_wen));
      chk("mem_wen", 64'(mem_wen), 64'(e.mwen));
      chk("mem_ren", 64'(mem_ren), 64'(e.mren));
      chk("mem_mask", 64'(mem_mask), 64'(e.mask));
      if (!e.illegal) chk("reg_w_sel", 64'(reg_w_sel), 64'(e.wsel));
      if (e.chk_imm) chk("imm", imm, e.imm);
      if (e.chk_alu) chk("alu_res", alu_res, e.alu);
    end
  end

  task automatic apply(input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] x, input logic [63:0] y);
    @(posedge clk);
    #1;
    inst = i; pc = p; rs1_data = x; rs2_data = y;
    @(negedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] i;
    logic [63:0] p, x, y;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV] = '{
    '{32'h0020C1B3, 64'h0, 64'hF0F0, 64'h0FF0},              // xor
    '{32'h0020E1B3, 64'h0, 64'hF000, 64'h000F},              // or
    '{32'h0020F1B3, 64'h0, 64'hFF00, 64'h0FF0},              // and
    '{32'h0020A1B3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1},  // slt -1 < 1
    '{32'h002091B3, 64'h0, 64'h1, 64'd64},                   // sll by 64 -> shamt 0
    '{32'h0020D1B3, 64'h0, 64'h8000_0000_0000_0000, 64'd4},  // srl
    '{32'h4040D093, 64'h0, 64'h8000_0000_0000_0000, 64'h0},  // srai 4
    '{32'h00014083, 64'h0, 64'h200, 64'h0},                  // lbu
    '{32'h00209023, 64'h0, 64'h300, 64'h5},                  // sh
    '{32'h00017083, 64'h0, 64'h200, 64'h0},                  // load funct3=7, illegal
    '{32'h0000C023, 64'h0, 64'h200, 64'h0},                  // store funct3=4, illegal
    '{32'h00000073, 64'h0, 64'h0, 64'h0},                    // ecall, illegal
    '{32'h0000000F, 64'h0, 64'h0, 64'h0},                    // fence, illegal
    '{32'h0020B1B3 | 32'h4000_0000, 64'h0, 64'h1, 64'h2},    // sltu with funct7=0x20, illegal
    '{32'h0010809B, 64'h0, 64'h7FFF_FFFF, 64'h0},            // addiw
    '{32'h402081BB, 64'h0, 64'h0, 64'h1}                     // subw
  };

  initial begin
    inst = 32'h0000_0013; pc = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_halted", 64'(halted), 64'h0);
    rst_n = 1'b1;

    apply(32'hFFB00093, 64'h0, 64'h0, 64'h0);                 // addi x1,x0,-5
    chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("addi_alu", alu_res, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("addi_wen", 64'(reg_wen), 64'h1);
    chk("addi_wsel", 64'(reg_w_sel), 64'h0);
    apply(32'h008000EF, 64'h8000_0000, 64'h0, 64'h0);         // jal +8
    chk("jal_alu", alu_res, 64'h8000_0008);
    chk("jal_pcsel", 64'(pc_sel), 64'h1);
    chk("jal_wsel", 64'(reg_w_sel), 64'h2);
    apply(32'h000100E7, 64'h0, 64'h1001, 64'h0);              // jalr
    chk("jalr_alu", alu_res, 64'h1000);
    apply(32'hFE20BC23, 64'h0, 64'h100, 64'h0);               // sd -8(x1)
    chk("sd_alu", alu_res, 64'hF8);
    chk("sd_mwen", 64'(mem_wen), 64'h1);
    chk("sd_mask", 64'(mem_mask), 64'hFF);
    apply(32'h00012083, 64'h0, 64'h40, 64'h0);                // lw
    chk("lw_mren", 64'(mem_ren), 64'h1);
    chk("lw_mask", 64'(mem_mask), 64'h0F);
    chk("lw_wsel", 64'(reg_w_sel), 64'h1);
    apply(32'h402081B3, 64'h0, 64'd3, 64'd5);                 // sub
    chk("sub_alu", alu_res, 64'hFFFF_FFFF_FFFF_FFFE);
    apply(32'h4020D1B3, 64'h0, 64'h8000_0000_0000_0000, 64'd63); // sra
    chk("sra_alu", alu_res, 64'hFFFF_FFFF_FFFF_FFFF);
    apply(32'h0020B1B3, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);  // sltu
    chk("sltu_alu", alu_res, 64'h1);
    apply(32'h123450B7, 64'h0, 64'h0, 64'h0);                 // lui
    chk("lui_alu", alu_res, 64'h1234_5000);
    apply(32'hFFFFF097, 64'h1000, 64'h0, 64'h0);              // auipc -0x1000
    chk("auipc_alu", alu_res, 64'h0);
    apply(32'h03F09093, 64'h0, 64'h1, 64'h0);                 // slli 63
    chk("slli_alu", alu_res, 64'h8000_0000_0000_0000);
    apply(32'h022081B3, 64'h0, 64'h3, 64'h5);                 // mul, illegal
    chk("mul_illegal", 64'(illegal), 64'h1);
    chk("mul_alu", alu_res, 64'h0);
    apply(32'h00000063, 64'h0, 64'h0, 64'h0);                 // beq, illegal
    chk("beq_illegal", 64'(illegal), 64'h1);
    apply(32'h0010809B, 64'h0, 64'h7FFF_FFFF, 64'h0);         // addiw
`ifdef RV64_WORD_OPS_EN
    chk("addiw_alu", alu_res, 64'hFFFF_FFFF_8000_0000);
`else
    chk("addiw_illegal", 64'(illegal), 64'h1);
`endif
    for (int k = 0; k < NV; k++) apply(vecs[k].i, vecs[k].p, vecs[k].x, vecs[k].y);

    apply(32'h0010_0073, 64'h0, 64'h0, 64'h0);                // ebreak
    chk("ebreak_flag", 64'(ebreak_flag), 64'h1);
    chk("ebreak_pcsel", 64'(pc_sel), 64'h0);
    chk("ebreak_not_yet_halted", 64'(halted), 64'h0);
    apply(32'hFFB00093, 64'h0, 64'h0, 64'h0);
    chk("halted_set", 64'(halted), 64'h1);
    chk("halted_addi_wen", 64'(reg_wen), 64'h0);
    chk("halted_addi_alu", alu_res, 64'hFFFF_FFFF_FFFF_FFFB);
    apply(32'hFE20BC23, 64'h0, 64'h100, 64'h0);
    chk("halted_sd_mwen", 64'(mem_wen), 64'h0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_clear", 64'(halted), 64'h0);
    #1 rst_n = 1'b1;
    apply(32'hFFB00093, 64'h0, 64'h0, 64'h0);
    chk("after_reset_wen", 64'(reg_wen), 64'h1);

    rst_n = 1'b0;
    apply(32'h0010_0073, 64'h0, 64'h0, 64'h0);
    @(posedge clk);
    #1;
    chk("reset_beats_ebreak", 64'(halted), 64'h0);
    inst = 32'h0000_0013;
    rst_n = 1'b1;
    apply(32'h00012083, 64'h0, 64'h40, 64'h0);
    chk("lw_after_reset_mren", 64'(mem_ren), 64'h1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: XLEN, 64, datapath width; only 64 is supported.
REQ-002 clk  input  1  clock; the halted register updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 inst  input  32  current instruction.
REQ-005 pc  input  64  address of the current instruction.
REQ-006 rs1_data / rs2_data  input  64 each  register-file read values.
REQ-007 imm  output  64  sign-extended immediate.
REQ-008 alu_res  output  64  ALU result; it is also the memory address and the jump target.
REQ-009 pc_sel  output  1  next-PC select: 0 = pc+4, 1 = alu_res.
REQ-010 reg_wen  output  1  register write enable.
REQ-011 reg_w_sel  output  2  register write-back source: 0 = ALU, 1 = memory, 2 = pc+4.
REQ-012 mem_wen / mem_ren  output  1 each  memory write / read enables.
REQ-013 mem_mask  output  8  byte-lane mask for memory access.
REQ-014 ebreak_flag  output  1  the current instruction is EBREAK.
REQ-015 illegal  output  1  the instruction is not supported.
REQ-016 halted  output  1  sticky halt state.

Function
REQ-017 All outputs except halted SHALL be combinational functions of inst, pc, rs1_data, rs2_data and halted.
REQ-018 Immediate formats SHALL be sign-extended to 64 bits as follows:
- I: inst[31:20]
- S: {inst[31:25], inst[11:7]}
- U: {inst[31:12], 12'b0}
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
- all other instructions: imm = 0.
REQ-019 ALU operations SHALL be ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, and PASS_B.
- Shift amounts use B[5:0].
- SLT and SLTU produce 0 or 1.
- All arithmetic wraps modulo 2^64.
REQ-020 The ALU A operand SHALL be pc for AUIPC and JAL, and rs1_data otherwise.
REQ-021 The ALU B operand SHALL be rs2_data for OP instructions, and imm otherwise.
REQ-022 LUI SHALL use PASS_B, with reg_wen=1 and reg_w_sel=0.
REQ-023 AUIPC SHALL compute pc+imm, with reg_wen=1 and reg_w_sel=0.
REQ-024 JAL and JALR SHALL set pc_sel=1, reg_wen=1 and reg_w_sel=2.
- For JALR, alu_res = (rs1_data+imm) with bit 0 cleared.
REQ-025 OP-IMM and OP instructions SHALL decode the ALU operation from funct3/funct7 and set reg_wen=1 with reg_w_sel=0.
- SUB and SRA/SRAI are selected when inst[30]=1.
REQ-026 LOAD instructions SHALL compute ADD of rs1+imm and set mem_ren=1, reg_wen=1 and reg_w_sel=1.
REQ-027 STORE instructions SHALL compute ADD of rs1+imm and set mem_wen=1 and reg_wen=0.
REQ-028 mem_mask SHALL follow funct3[1:0] for both loads and stores: 0→0x01, 1→0x03, 2→0x0F, 3→0xFF.
- mem_mask is 0x00 for all other instructions.
REQ-029 ebreak_flag SHALL be 1 only when inst == 0x00100073.
REQ-030 An unsupported opcode or funct encoding SHALL set illegal=1.
- reg_wen, mem_wen, mem_ren and pc_sel are all 0; alu_res = 0.
REQ-031 On a rising clk edge with ebreak_flag=1, halted SHALL become 1 and stay 1 until reset.
REQ-032 While halted=1, reg_wen, mem_wen and mem_ren SHALL be forced to 0; decode otherwise continues unchanged.
REQ-033 For EBREAK, no enable SHALL be asserted and pc_sel SHALL be 0.

Reset
REQ-034 rst_n=0 SHALL clear halted to 0 immediately, independent of clk.
REQ-035 Reset asserted in the same cycle as EBREAK SHALL take priority: halted remains 0.

Configuration
REQ-036 When RV64_WORD_OPS_EN is defined, the block SHALL support ADDIW, SLLIW, SRLIW, SRAIW, ADDW, SUBW, SLLW, SRLW and SRAW.
- These operate on the low 32 bits, use 5-bit shift amounts, and produce a sign-extended 32-bit result.
- They write back through reg_w_sel=0.
REQ-037 When RV64_WORD_OPS_EN is not defined, opcodes 0x1B and 0x3B SHALL be treated as illegal (REQ-030).

Verification
REQ-038 addi x1,x0,-5 (0xFFB00093), rs1=0 -> imm=0xFFFF_FFFF_FFFF_FFFB, alu_res=0xFFFF_FFFF_FFFF_FFFB, reg_wen=1, reg_w_sel=0.
REQ-039 jal with imm=8, pc=0x8000_0000 -> alu_res=0x8000_0008, pc_sel=1, reg_w_sel=2; jalr with rs1=0x1001, imm=0 -> alu_res=0x1000.
REQ-040 sd (funct3=3), rs1=0x100, imm=-8 -> alu_res=0xF8, mem_wen=1, mem_mask=0xFF; lw -> mem_ren=1, mem_mask=0x0F, reg_w_sel=1.
REQ-041 sub rs1=3, rs2=5 -> 0xFFFF_FFFF_FFFF_FFFE; sra of 0x8000_0000_0000_0000 by 63 -> all ones; sltu 1 vs all-ones -> 1.
REQ-042 EBREAK followed by a clk edge -> halted=1 and a subsequent addi gives reg_wen=0; rst_n low mid-cycle -> halted=0 at once.
REQ-043 With RV64_WORD_OPS_EN defined, addiw on rs1=0x7FFF_FFFF with imm=1 -> 0xFFFF_FFFF_8000_0000; without the macro, the same instruction gives illegal=1.
